hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load scoreboard, RAW stall, redirect flush,
// memory-busy freeze with timeout. Optional macro HAZARD_WB_BYPASS_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_id,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic        rs1Used_id,
  input  logic        rs2Used_id,
  input  logic [4:0]  rdAddr_id,
  input  logic        RegWrite_id,
  input  logic        MemRead_id,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        MemAccess_mem,
  input  logic        MemReady,
  input  logic        RegWrite_wb,
  input  logic        MemtoReg_wb,
  input  logic [4:0]  rdAddr_wb,
  output logic        PCWrite,
  output logic        IFWrite,
  output logic        Stall,
  output logic        IF_flush,
  output logic        Freeze,
  output logic        MemErr,
  output logic [31:0] Pending
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [31:0] pend_q, pend_nxt, pend_view, set_mask, clr_mask;
  logic        freeze_int, hazard, stall_int, set_en, clr_en;

  always_comb begin
    set_mask   = 32'(1) << rdAddr_id;
    clr_mask   = 32'(1) << rdAddr_wb;
    freeze_int = (state != ERR) & MemAccess_mem & ~MemReady;
    clr_en     = RegWrite_wb & MemtoReg_wb & ~freeze_int;
`ifdef HAZARD_WB_BYPASS_EN
    // register file writes through, so a register retiring now is readable now
    pend_view  = pend_q & ~(clr_en ? clr_mask : 32'd0);
`else
    pend_view  = pend_q;
`endif
    hazard     = valid_id &
                 ((rs1Used_id & (rs1Addr_id != 5'd0) & pend_view[rs1Addr_id]) |
                  (rs2Used_id & (rs2Addr_id != 5'd0) & pend_view[rs2Addr_id]));
    stall_int  = ~freeze_int & hazard;
    set_en     = valid_id & MemRead_id & RegWrite_id & (rdAddr_id != 5'd0) &
                 ~stall_int & ~freeze_int;
    pend_nxt   = ((pend_q & ~(clr_en ? clr_mask : 32'd0)) |
                  (set_en ? set_mask : 32'd0)) & ~32'd1;
  end

  // count holds freeze cycles already spent before the current one
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: if (MemAccess_mem & ~MemReady) begin
        state_nxt = WAIT;
        count_nxt = 8'd1;
      end
      WAIT: if (MemReady | ~MemAccess_mem) begin
        state_nxt = IDLE;
        count_nxt = 8'd0;
      end else if (count == CNT_LAST) begin
        state_nxt = ERR;
        count_nxt = 8'd0;
      end else begin
        count_nxt = count + 8'd1;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 8'd0;
      pend_q <= 32'd0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      pend_q <= pend_nxt;
    end
  end

  always_comb begin
    PCWrite  = 1'b1;
    IFWrite  = 1'b1;
    Stall    = 1'b0;
    IF_flush = 1'b0;
    Freeze   = freeze_int;
    MemErr   = (state == ERR);
    if (rst) begin
      PCWrite  = 1'b0;
      IFWrite  = 1'b0;
      IF_flush = 1'b1;
      Freeze   = 1'b0;
      MemErr   = 1'b0;
    end else if (freeze_int) begin
      PCWrite = 1'b0;
      IFWrite = 1'b0;
    end else if (hazard) begin
      // redirect operands are stale while stalled, so branch is ignored
      Stall   = 1'b1;
      PCWrite = 1'b0;
      IFWrite = 1'b0;
    end else if (valid_id & (Branch | Jump)) begin
      IF_flush = 1'b1;
    end
  end

  assign Pending = pend_q;

endmodule
